// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential fetch requests under a credit
// limit and buffers in-order responses as {instr, pc} entries for IF/ID.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        req_valid,
    output logic [31:0] req_addr,
    input  logic        req_ready,
    input  logic        resp_valid,
    input  logic [31:0] resp_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    // Drops can stack across repeated redirects, so this counter gets headroom.
    localparam int DW = CW + 4;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [DW-1:0] drop_cnt_q, drop_cnt_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   mem_q [DEPTH];

    logic [CW:0] credit_used;
    logic        req_fire;
    logic        resp_hit;
    logic        drop;
    logic        enq;
    logic        deq;
    logic [63:0] head;

    assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};
    assign req_valid   = !reset && !redirect_valid && (credit_used < DEPTH_C);
    assign req_addr    = fetch_pc_q;
    assign req_fire    = req_valid && req_ready;

    // A response only counts if something is outstanding; stray ones are ignored.
    assign resp_hit = resp_valid && ((inflight_q != '0) || (drop_cnt_q != '0));
    assign drop     = resp_valid && !redirect_valid && (drop_cnt_q != '0);
    assign enq      = resp_valid && !redirect_valid && (drop_cnt_q == '0) && (inflight_q != '0);
    assign deq      = out_valid && out_ready && !redirect_valid;

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign out_instr = head[63:32];
    assign out_pc    = head[31:0];
    assign out_pc4   = out_pc + 32'd4;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            // Everything still outstanding becomes a response to discard.
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            inflight_d = '0;
            drop_cnt_d = drop_cnt_q + DW'(inflight_q) - DW'(resp_hit);
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (drop) begin
                drop_cnt_d = drop_cnt_q - DW'(1);
            end
            if (enq) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = wr_ptr_q + AW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            inflight_d = inflight_q + CW'(req_fire) - CW'(enq);
            count_d    = count_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= {resp_instr, resp_pc_q};
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, backpressure, redirects, async
// reset and address wrap, with hand-computed expectations.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;

    int n_checks = 0;
    int n_pass   = 0;
    int num_req  = 0;
    logic auto_mem = 1'b0;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_instr     (resp_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc4        (out_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) begin
            assert (!(dut.enq && int'(dut.count_q) == DEPTH))
                else $error("FAIL fifo_overflow: enqueue with occupancy %0d, required < %0d", dut.count_q, DEPTH);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %s: got %h", tag, got);
        end else begin
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    // One clock; with auto_mem the bench acts as a 1-cycle-latency memory
    // returning ~addr as the instruction word.
    task automatic tick();
        logic        fire;
        logic [31:0] a;
        #1;
        fire = req_valid && req_ready;
        a    = req_addr;
        if (fire) num_req++;
        @(posedge clk);
        #1;
        if (auto_mem) begin
            resp_valid = fire;
            resp_instr = ~a;
        end
        #1;
    endtask

    task automatic do_reset();
        auto_mem       = 1'b0;
        resp_valid     = 1'b0;
        redirect_valid = 1'b0;
        req_ready      = 1'b0;
        out_ready      = 1'b0;
        num_req        = 0;
        reset          = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b1;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_instr     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;

        // Reset state and first request after release
        #2;
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_req_valid", 32'(req_valid), 32'd1);
        check("post_rst_req_addr", req_addr, 32'h0);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Streaming, one output per cycle after fill
        req_ready = 1'b1;
        out_ready = 1'b1;
        auto_mem  = 1'b1;
        tick();
        check("stream_fill_out_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("stream_out_valid", 32'(out_valid), 32'd1);
            check("stream_out_pc", out_pc, 32'(4 * k));
            check("stream_out_instr", out_instr, ~32'(4 * k));
            check("stream_out_pc4", out_pc4, 32'(4 * k + 4));
        end

        // Asynchronous reset between edges
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_req_valid", 32'(req_valid), 32'd0);
        auto_mem   = 1'b0;
        resp_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_rel_req_addr", req_addr, 32'h0);
        check("async_rel_req_valid", 32'(req_valid), 32'd1);
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_instr = 32'h5555_AAAA;
        tick();
        resp_valid = 1'b0;
        #1;
        check("stray_resp_ignored", 32'(out_valid), 32'd0);

        // Backpressure: exactly DEPTH requests, head held, then ordered drain
        do_reset();
        req_ready = 1'b1;
        auto_mem  = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        check("bp_num_req", 32'(num_req), 32'd4);
        check("bp_req_valid", 32'(req_valid), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_out_pc_held", out_pc, 32'h0);
        check("bp_out_instr_held", out_instr, 32'hFFFF_FFFF);
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("bp_drain_pc", out_pc, 32'(4 * k));
        end

        // Redirect with two requests in flight
        do_reset();
        out_ready = 1'b1;
        req_ready = 1'b1;
        tick();
        tick();
        req_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        #1;
        check("redir_req_valid_low", 32'(req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("redir_req_addr", req_addr, 32'h0000_0100);
        resp_valid = 1'b1;
        resp_instr = 32'hDEAD_0001;
        tick();
        check("redir_drop1", 32'(out_valid), 32'd0);
        resp_instr = 32'hDEAD_0002;
        tick();
        check("redir_drop2", 32'(out_valid), 32'd0);
        resp_valid = 1'b0;
        req_ready  = 1'b1;
        tick();
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_instr = 32'hCAFE_0100;
        tick();
        resp_valid = 1'b0;
        #1;
        check("redir_out_valid", 32'(out_valid), 32'd1);
        check("redir_out_pc", out_pc, 32'h0000_0100);
        check("redir_out_instr", out_instr, 32'hCAFE_0100);
        check("redir_out_pc4", out_pc4, 32'h0000_0104);

        // Redirect coincident with a response, three in flight, FIFO non-empty
        do_reset();
        req_ready = 1'b1;
        tick();
        tick();
        tick();
        resp_valid = 1'b1;
        resp_instr = 32'h0BAD_0000;
        tick();
        resp_valid = 1'b0;
        req_ready  = 1'b0;
        #1;
        check("coinc_pre_out_valid", 32'(out_valid), 32'd1);
        check("coinc_pre_req_valid", 32'(req_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        resp_valid     = 1'b1;
        resp_instr     = 32'h0BAD_0004;
        tick();
        redirect_valid = 1'b0;
        resp_valid     = 1'b0;
        #1;
        check("coinc_fifo_empty", 32'(out_valid), 32'd0);
        check("coinc_req_addr", req_addr, 32'h0000_0100);
        check("coinc_req_valid", 32'(req_valid), 32'd1);
        resp_valid = 1'b1;
        resp_instr = 32'h0BAD_0008;
        tick();
        resp_instr = 32'h0BAD_000C;
        tick();
        check("coinc_dropped", 32'(out_valid), 32'd0);
        resp_valid = 1'b0;
        req_ready  = 1'b1;
        tick();
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_instr = 32'hBEEF_0100;
        tick();
        resp_valid = 1'b0;
        #1;
        check("coinc_out_pc", out_pc, 32'h0000_0100);
        check("coinc_out_instr", out_instr, 32'hBEEF_0100);

        // Back-to-back redirects: last wins, drops stay cumulative
        do_reset();
        req_ready = 1'b1;
        tick();
        tick();
        req_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_pc = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("b2b_req_addr", req_addr, 32'h0000_0300);
        resp_valid = 1'b1;
        resp_instr = 32'h1111_0000;
        tick();
        tick();
        resp_valid = 1'b0;
        req_ready  = 1'b1;
        tick();
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_instr = 32'h3333_0300;
        tick();
        resp_valid = 1'b0;
        #1;
        check("b2b_out_pc", out_pc, 32'h0000_0300);
        check("b2b_out_instr", out_instr, 32'h3333_0300);

        // Fetch address wrap at the top of the address space
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        req_ready      = 1'b1;
        #1;
        check("wrap_req_addr0", req_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_req_addr1", req_addr, 32'h0000_0000);
        req_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_instr = 32'h1234_5678;
        tick();
        resp_valid = 1'b0;
        #1;
        check("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
        check("wrap_out_pc4", out_pc4, 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
